// File: rtl/nasti_wr_sched.sv
// NASTI write-path scheduler: round-robin AW grant held through the W burst,
// outstanding-write table for B routing. Optional W-stall watchdog: NASTI_WR_SCHED_TIMEOUT_EN.
module nasti_wr_sched #(
    parameter int N_PORT    = 8,
    parameter int W_MAX     = 2,
    parameter int ID_WIDTH  = 1,
    parameter int LITE_MODE = 0,
    parameter int TIMEOUT   = 1024,
    localparam int SEL_W    = $clog2(N_PORT),
    localparam int IDX_W    = $clog2(W_MAX)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_PORT-1:0]   aw_valid_i,
    input  logic [N_PORT-1:0]   w_valid_i,
    input  logic [N_PORT-1:0]   w_last_i,
    input  logic [ID_WIDTH-1:0] aw_id_s,
    input  logic                aw_ready_s,
    input  logic                w_ready_s,
    input  logic                b_valid_s,
    input  logic [ID_WIDTH-1:0] b_id_s,
    input  logic                b_ready_s,
    output logic [SEL_W-1:0]    sel_o,
    output logic                aw_gate_o,
    output logic                w_gate_o,
    output logic [SEL_W-1:0]    b_sel_o,
    output logic                b_hit_o,
    output logic                b_orphan_o,
    output logic                full_o,
    output logic                timeout_o
);

    typedef enum logic [1:0] {
        ST_ARB,
        ST_AW,
        ST_W
    } state_e;

    localparam logic LITE = (LITE_MODE != 0);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0]    last_q, last_d;
    logic                aw_gate_q, aw_gate_d;
    logic                w_gate_q, w_gate_d;
    logic [W_MAX-1:0]    valid_q, valid_d;
    logic [ID_WIDTH-1:0] id_q [W_MAX];
    logic [ID_WIDTH-1:0] id_d [W_MAX];
    logic [SEL_W-1:0]    port_q [W_MAX];
    logic [SEL_W-1:0]    port_d [W_MAX];

    logic                pick_vld;
    logic [SEL_W-1:0]    pick;
    int                  arb_idx;
    logic                alloc_ok;
    logic [IDX_W-1:0]    alloc_idx;
    logic                b_hit;
    logic [IDX_W-1:0]    b_idx;
    logic                aw_fire;
    logic                w_fire;
    logic                w_done;

    assign full_o  = &valid_q;
    assign aw_fire = (state_q == ST_AW) & aw_valid_i[sel_q] & aw_ready_s;
    assign w_fire  = (state_q == ST_W) & w_valid_i[sel_q] & w_ready_s;
    assign w_done  = w_fire & (w_last_i[sel_q] | LITE);

    // Round-robin: first requester after the last granted port, with wrap.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        arb_idx  = 0;
        for (int i = 1; i <= N_PORT; i++) begin
            arb_idx = (int'(last_q) + i) % N_PORT;
            if (!pick_vld && aw_valid_i[arb_idx]) begin
                pick_vld = 1'b1;
                pick     = SEL_W'(arb_idx);
            end
        end
    end

    always_comb begin
        alloc_ok  = 1'b0;
        alloc_idx = '0;
        for (int i = 0; i < W_MAX; i++) begin
            if (!alloc_ok && !valid_q[i]) begin
                alloc_ok  = 1'b1;
                alloc_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        b_hit = 1'b0;
        b_idx = '0;
        for (int i = 0; i < W_MAX; i++) begin
            if (!b_hit && b_valid_s && valid_q[i] && id_q[i] == b_id_s) begin
                b_hit = 1'b1;
                b_idx = IDX_W'(i);
            end
        end
    end

    assign b_hit_o    = b_hit;
    assign b_sel_o    = b_hit ? port_q[b_idx] : '0;
    assign b_orphan_o = b_valid_s & ~b_hit;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        aw_gate_d = 1'b0;
        w_gate_d  = 1'b0;
        valid_d   = valid_q;
        id_d      = id_q;
        port_d    = port_q;
        if (b_valid_s && b_ready_s && b_hit) begin
            valid_d[b_idx] = 1'b0;
        end
        unique case (state_q)
            ST_ARB: begin
                if (pick_vld && !full_o) begin
                    sel_d     = pick;
                    state_d   = ST_AW;
                    aw_gate_d = 1'b1;
                end
            end
            ST_AW: begin
                aw_gate_d = 1'b1;
                if (aw_fire) begin
                    // alloc_idx comes from pre-cycle bits, never the freed slot
                    valid_d[alloc_idx] = 1'b1;
                    id_d[alloc_idx]    = aw_id_s;
                    port_d[alloc_idx]  = sel_q;
                    last_d             = sel_q;
                    state_d            = ST_W;
                    aw_gate_d          = 1'b0;
                    w_gate_d           = 1'b1;
                end
            end
            ST_W: begin
                w_gate_d = 1'b1;
                if (w_done) begin
                    state_d  = ST_ARB;
                    w_gate_d = 1'b0;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ARB;
            sel_q     <= '0;
            last_q    <= SEL_W'(N_PORT - 1);
            aw_gate_q <= 1'b0;
            w_gate_q  <= 1'b0;
            valid_q   <= '0;
            for (int i = 0; i < W_MAX; i++) begin
                id_q[i]   <= '0;
                port_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            aw_gate_q <= aw_gate_d;
            w_gate_q  <= w_gate_d;
            valid_q   <= valid_d;
            id_q      <= id_d;
            port_q    <= port_d;
        end
    end

    assign sel_o     = sel_q;
    assign aw_gate_o = aw_gate_q;
    assign w_gate_o  = w_gate_q;

`ifdef NASTI_WR_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;

    // Counts stalled W cycles, saturating at the limit.
    always_comb begin
        cnt_d = cnt_q;
        tmo_d = tmo_q;
        if (aw_fire) begin
            cnt_d = '0;
        end else if (state_q == ST_W) begin
            if (w_fire) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_W'(TIMEOUT)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (cnt_d == CNT_W'(TIMEOUT)) begin
            tmo_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout_o = tmo_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_nasti_wr_sched.sv
// Self-checking bench for nasti_wr_sched: directed scenarios then random
// traffic against a transaction-level reference model.
module tb_nasti_wr_sched;

    localparam int N    = 8;
    localparam int WM   = 2;
    localparam int IDW  = 1;
    localparam int LITE = 0;
`ifdef NASTI_WR_SCHED_TIMEOUT_EN
    localparam int TMO  = 16;
`else
    localparam int TMO  = 1024;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   aw_valid_i = '0;
    logic [N-1:0]   w_valid_i = '0;
    logic [N-1:0]   w_last_i = '0;
    logic [IDW-1:0] aw_id_s = '0;
    logic           aw_ready_s = 1'b0;
    logic           w_ready_s = 1'b0;
    logic           b_valid_s = 1'b0;
    logic [IDW-1:0] b_id_s = '0;
    logic           b_ready_s = 1'b0;
    logic [2:0]     sel_o;
    logic           aw_gate_o;
    logic           w_gate_o;
    logic [2:0]     b_sel_o;
    logic           b_hit_o;
    logic           b_orphan_o;
    logic           full_o;
    logic           timeout_o;

    nasti_wr_sched #(
        .N_PORT(N), .W_MAX(WM), .ID_WIDTH(IDW),
        .LITE_MODE(LITE), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .aw_valid_i(aw_valid_i), .w_valid_i(w_valid_i), .w_last_i(w_last_i),
        .aw_id_s(aw_id_s), .aw_ready_s(aw_ready_s), .w_ready_s(w_ready_s),
        .b_valid_s(b_valid_s), .b_id_s(b_id_s), .b_ready_s(b_ready_s),
        .sel_o(sel_o), .aw_gate_o(aw_gate_o), .w_gate_o(w_gate_o),
        .b_sel_o(b_sel_o), .b_hit_o(b_hit_o), .b_orphan_o(b_orphan_o),
        .full_o(full_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

`define CHK(tag, o, e) begin \
    checks++; \
    assert ((o) === (e)) else begin \
        errors++; \
        $error("FAIL %s obs=%0h exp=%0h", tag, o, e); \
    end \
end

    task automatic tally(input bit ok, input string tag);
        checks++;
        if (!ok) begin
            errors++;
            $error("FAIL %s", tag);
        end
    endtask

    // Reference model: phase 0=arbitrate, 1=address, 2=data
    int ph;
    int m_sel;
    int m_last;
    bit m_v [WM];
    int m_id [WM];
    int m_port [WM];
    int tcnt;
    bit tmo;

    task automatic m_reset();
        ph = 0;
        m_sel = 0;
        m_last = N - 1;
        tcnt = 0;
        tmo = 0;
        for (int i = 0; i < WM; i++) begin
            m_v[i] = 0;
            m_id[i] = 0;
            m_port[i] = 0;
        end
    endtask

    function automatic int m_bmatch();
        int r = -1;
        for (int i = 0; i < WM; i++) begin
            if (r < 0 && b_valid_s && m_v[i] && m_id[i] == int'(b_id_s)) r = i;
        end
        return r;
    endfunction

    function automatic bit m_full();
        bit f = 1;
        for (int i = 0; i < WM; i++) f = f & m_v[i];
        return f;
    endfunction

    task automatic check_cycle(string tag);
        int bi;
        bit exp_t;
        bi = m_bmatch();
`ifdef NASTI_WR_SCHED_TIMEOUT_EN
        exp_t = tmo;
`else
        exp_t = 1'b0;
`endif
        `CHK($sformatf("%s.sel", tag), sel_o, 3'(m_sel))
        `CHK($sformatf("%s.aw_gate", tag), aw_gate_o, (ph == 1))
        `CHK($sformatf("%s.w_gate", tag), w_gate_o, (ph == 2))
        `CHK($sformatf("%s.b_hit", tag), b_hit_o, (bi >= 0))
        `CHK($sformatf("%s.b_sel", tag), b_sel_o, 3'((bi >= 0) ? m_port[bi] : 0))
        `CHK($sformatf("%s.b_orphan", tag), b_orphan_o, (b_valid_s && bi < 0))
        `CHK($sformatf("%s.full", tag), full_o, m_full())
        `CHK($sformatf("%s.timeout", tag), timeout_o, exp_t)
    endtask

    task automatic m_advance();
        int bi;
        int ai;
        bit f;
        bi = m_bmatch();
        f = m_full();
        ai = -1;
        for (int i = 0; i < WM; i++) if (ai < 0 && !m_v[i]) ai = i;
        if (b_ready_s && bi >= 0) m_v[bi] = 0;
        case (ph)
            0: begin
                if (aw_valid_i != 0 && !f) begin
                    for (int j = N; j >= 1; j--) begin
                        if (aw_valid_i[(m_last + j) % N]) m_sel = (m_last + j) % N;
                    end
                    ph = 1;
                end
            end
            1: begin
                if (aw_valid_i[m_sel] && aw_ready_s) begin
                    m_v[ai] = 1;
                    m_id[ai] = int'(aw_id_s);
                    m_port[ai] = m_sel;
                    m_last = m_sel;
                    tcnt = 0;
                    ph = 2;
                end
            end
            default: begin
                if (w_valid_i[m_sel] && w_ready_s) begin
                    tcnt = 0;
                    if (w_last_i[m_sel] || LITE != 0) ph = 0;
                end else if (tcnt < TMO) begin
                    tcnt++;
                    if (tcnt == TMO) tmo = 1;
                end
            end
        endcase
    endtask

    task automatic cyc(string tag);
        #1;
        check_cycle(tag);
        m_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(string tag);
        rst = 1'b1;
        #1;
        m_reset();
        `CHK($sformatf("%s.rst_sel", tag), sel_o, 3'd0)
        `CHK($sformatf("%s.rst_awg", tag), aw_gate_o, 1'b0)
        `CHK($sformatf("%s.rst_wg", tag), w_gate_o, 1'b0)
        `CHK($sformatf("%s.rst_full", tag), full_o, 1'b0)
        `CHK($sformatf("%s.rst_tmo", tag), timeout_o, 1'b0)
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drive(input logic [N-1:0] aw, input logic [N-1:0] wv,
                         input logic [N-1:0] wl, input logic awr,
                         input logic wr, input logic bv, input logic br);
        aw_valid_i = aw;
        w_valid_i = wv;
        w_last_i = wl;
        aw_ready_s = awr;
        w_ready_s = wr;
        b_valid_s = bv;
        b_ready_s = br;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int gq[$];
        int beats;
        bit fire;
        int exp_g [4] = '{0, 2, 0, 2};
        bit exp_t;
`ifdef NASTI_WR_SCHED_TIMEOUT_EN
        exp_t = 1'b1;
`else
        exp_t = 1'b0;
`endif
        @(posedge clk);
        #1;
        do_reset("init");

        // Round-robin between ports 0 and 2, B retiring every write
        drive(8'b0000_0101, '1, '1, 1, 1, 1, 1);
        aw_id_s = '0;
        b_id_s = '0;
        for (int c = 0; c < 12; c++) begin
            if (aw_gate_o) gq.push_back(int'(sel_o));
            cyc("rr");
        end
        tally(gq.size() == 4, "rr.count");
        for (int k = 0; k < 4; k++) begin
            if (k < gq.size())
                tally(gq[k] == exp_g[k], $sformatf("rr.grant%0d", k));
        end

        // Table full blocks port 5 until a B frees an entry
        do_reset("full");
        drive(8'b0010_1010, '1, '1, 1, 1, 0, 1);
        for (int c = 0; c < 8; c++) begin
            aw_id_s = (m_sel == 1) ? 1'b0 : 1'b1;
            cyc("full");
        end
        tally(full_o === 1'b1, "full.flag");
        tally(aw_gate_o === 1'b0, "full.blocked");
        b_valid_s = 1'b1;
        b_id_s = 1'b0;
        #1;
        tally(b_sel_o === 3'd1, "full.bsel");
        cyc("full.free");
        b_valid_s = 1'b0;
        cyc("full.arb");
        tally(aw_gate_o === 1'b1, "full.p5_gate");
        tally(sel_o === 3'd5, "full.p5_sel");

        // Four-beat burst with toggling w_ready; port 6 must wait
        do_reset("burst");
        drive(8'b0100_0100, '1, '0, 1, 0, 0, 1);
        beats = 0;
        for (int c = 0; c < 40 && beats < 4; c++) begin
            w_ready_s = c[0];
            w_last_i = (beats == 3) ? '1 : '0;
            fire = (ph == 2) && w_ready_s;
            cyc("burst");
            if (fire) beats++;
        end
        tally(beats == 4, "burst.beats");
        tally(w_gate_o === 1'b0, "burst.released");
        cyc("burst.arb");
        tally(aw_gate_o === 1'b1, "burst.p6_gate");
        tally(sel_o === 3'd6, "burst.p6_sel");

        // B routing by ID and orphan on an empty table
        do_reset("broute");
        drive(8'b0001_0010, '1, '1, 1, 1, 0, 1);
        for (int c = 0; c < 6; c++) begin
            aw_id_s = (m_sel == 1) ? 1'b0 : 1'b1;
            cyc("broute");
        end
        aw_valid_i = '0;
        b_valid_s = 1'b1;
        b_id_s = 1'b1;
        #1;
        tally(b_hit_o === 1'b1, "broute.id1_hit");
        tally(b_sel_o === 3'd4, "broute.id1_sel");
        cyc("broute.id1");
        b_id_s = 1'b0;
        #1;
        tally(b_sel_o === 3'd1, "broute.id0_sel");
        cyc("broute.id0");
        b_id_s = 1'b1;
        #1;
        tally(b_orphan_o === 1'b1, "broute.orphan");
        cyc("broute.orph");
        b_valid_s = 1'b0;
        cyc("broute.idle");

        // Alloc into entry 1 while B frees entry 0 in the same cycle
        do_reset("same");
        drive(8'b0000_1001, '1, '1, 1, 1, 0, 1);
        b_id_s = 1'b0;
        for (int c = 0; c < 6; c++) begin
            aw_id_s = (m_sel == 0) ? 1'b0 : 1'b1;
            b_valid_s = (ph == 1) && (m_sel == 3);
            cyc("same");
        end
        aw_valid_i = '0;
        b_valid_s = 1'b1;
        b_id_s = 1'b0;
        #1;
        tally(b_orphan_o === 1'b1, "same.e0_freed");
        b_id_s = 1'b1;
        #1;
        tally(b_sel_o === 3'd3, "same.e1_sel");
        tally(full_o === 1'b0, "same.not_full");
        b_valid_s = 1'b0;
        cyc("same.end");

        // W stall watchdog and reset mid-burst
        do_reset("stall");
        drive(8'b0000_0001, '0, '0, 1, 1, 0, 1);
        for (int c = 0; c < 22; c++) cyc("stall");
        tally(timeout_o === exp_t, "stall.tmo");
        w_valid_i = '1;
        w_last_i = '1;
        cyc("stall.done");
        aw_valid_i = '0;
        cyc("stall.after");
        tally(timeout_o === exp_t, "stall.sticky");
        aw_valid_i = 8'b0000_0001;
        w_valid_i = '0;
        for (int c = 0; c < 4; c++) cyc("stall.mid");
        do_reset("midrst");
        cyc("midrst.post");

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            aw_valid_i = N'($urandom_range(0, 255) & $urandom_range(0, 255));
            w_valid_i = N'($urandom);
            w_last_i = N'($urandom);
            aw_ready_s = ($urandom % 4) != 0;
            w_ready_s = ($urandom % 4) != 0;
            b_valid_s = ($urandom % 3) == 0;
            b_ready_s = ($urandom % 4) != 0;
            b_id_s = IDW'($urandom);
            aw_id_s = IDW'($urandom);
            if (c % 997 == 500) do_reset("rnd");
            else cyc("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nasti_wr_sched.md
Name: nasti_wr_sched

Overview:
Write-path scheduler for the NASTI multiplexer that merges up to N master ports onto one slave port.
- Arbitrates AW requests round-robin.
- Holds the grant for the AW handshake and the whole W burst.
- Tracks outstanding writes in a table so that B responses route back to the issuing port.
- Drives only select and gate signals; the companion datapath mux steers the payload.

Parameters:
N_PORT, 8, number of master ports (2..8)
W_MAX, 2, outstanding write table entries (power of 2, >=2)
ID_WIDTH, 1, AXI ID width
LITE_MODE, 0, 1 = every W burst is one beat; w_last ignored
TIMEOUT, 1024, W-stall watchdog limit in cycles (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
aw_valid_i  in  N_PORT  per-port AW valid
w_valid_i  in  N_PORT  per-port W valid
w_last_i  in  N_PORT  per-port W last
aw_id_s  in  ID_WIDTH  AW ID of the selected port (from the mux)
aw_ready_s  in  1  slave AW ready
w_ready_s  in  1  slave W ready
b_valid_s  in  1  slave B valid
b_id_s  in  ID_WIDTH  slave B ID
b_ready_s  in  1  B ready of the routed port (mux returns master b_ready[b_sel_o]; forced 1 when b_orphan_o)
sel_o  out  clog2(N_PORT)  port steering AW/W
aw_gate_o  out  1  slave aw_valid = aw_gate_o & aw_valid_i[sel_o]
w_gate_o  out  1  slave w_valid = w_gate_o & w_valid_i[sel_o]
b_sel_o  out  clog2(N_PORT)  destination port of the current B
b_hit_o  out  1  current B matches a table entry
b_orphan_o  out  1  b_valid_s with no matching entry
full_o  out  1  all W_MAX entries valid
timeout_o  out  1  sticky W-stall flag (optional feature)

Behaviour:
- Reset: state=ARB; sel_o=0; gates=0; table valid bits=0; last_grant=N_PORT-1, so port 0 has highest priority; timeout_o=0.
- Reset takes effect immediately mid-burst. The table is cleared and in-flight transactions are dropped.
- FSM ARB:
  - Condition to grant: |aw_valid_i and !full_o.
  - Pick the first requesting port searching from last_grant+1 with wrap.
  - Register the pick into sel_o and move to AW.
  - There is a one-cycle bubble between grant and AW presentation.
- FSM AW:
  - aw_gate_o=1; sel_o is frozen.
  - On aw_valid_i[sel_o] & aw_ready_s:
    - Write {aw_id_s, sel_o} into the lowest free entry and set it valid.
    - last_grant <= sel_o.
    - Move to W.
  - If aw_valid_i[sel_o] drops, remain in AW; there is no re-arbitration.
- FSM W:
  - w_gate_o=1.
  - On w_valid_i[sel_o] & w_ready_s & (w_last_i[sel_o] | LITE_MODE), return to ARB.
  - Other beats stay in W.
- aw_gate_o and w_gate_o are never both 1.
- B routing (combinational):
  - Match when entry valid & id==b_id_s & b_valid_s.
  - The lowest matching index wins (oldest-first within the same ID is not guaranteed; same-ID writes to different ports are a system-level restriction).
  - b_hit_o = any match.
  - b_sel_o = port of the winning entry, else 0.
  - b_orphan_o = b_valid_s & !b_hit_o.
- Free: on b_valid_s & b_ready_s & b_hit_o, clear the winning entry's valid bit. An orphan handshake frees nothing.
- Alloc and free in the same cycle are both applied. The alloc index is chosen from pre-cycle valid bits, so the two entries differ.
- full_o = &valid. An entry freed in cycle t is grantable in ARB at t+1.

Optional Feature:
Macro NASTI_WR_SCHED_TIMEOUT_EN.
- Defined:
  - A counter runs in W; it clears on any W handshake and on entry to W.
  - When the count reaches TIMEOUT, timeout_o is set and stays set until rst.
  - The FSM is unaffected.
- Undefined:
  - The counter is absent.
  - timeout_o is tied to 0 and the TIMEOUT parameter is unused.

Test Plan:
1. aw_valid_i=8'b0000_0101, ready always 1, 1-beat bursts → grants in order port 0, 2, 0, 2; sel_o changes only in ARB; one bubble cycle each.
2. W_MAX=2, no B returned, ports 1, 3, 5 request → two AWs accepted, full_o=1, port 5 waits in ARB; B id matching port 1 handshakes → port 5 granted the next cycle.
3. 4-beat burst on port 2 with w_ready_s toggling every cycle → w_gate_o held until the 4th beat with last; port 6 aw_valid ignored until then; LITE_MODE=1 → released after 1 beat.
4. Entries id0→port 1 and id1→port 4; B id1 then B id0 → b_sel_o=4 then 1, b_hit_o=1; B id1 while table empty → b_orphan_o=1, table unchanged.
5. Same cycle: AW accepted into entry 1 while B frees entry 0 → both applied, valid=2'b10.
6. Macro on, TIMEOUT=16: W state with w_valid_i=0 for 16 cycles → timeout_o=1 and stays 1 after the burst completes; assert rst mid-burst → state ARB, table empty, timeout_o=0.
